anode_scan_ctrl: RTL and testbench
==================================

// Module: anode_scan_ctrl
// PURPOSE
//  Parametrised, time-multiplexed seven-segment display scanner; successor to the 2-bit anode_mux.
//  Cycles an internal digit index over NUM_DIGITS slots and drives one-hot anodes, hex-decoded segments and dp.
//  Adds refresh prescaler, per-digit enable, inter-digit dead time and frame-synchronous shadowing.
//  Sits between the ALU result/formatting logic and the board display pins.
// PARAMETERS
//  NUM_DIGITS   4       digits scanned, 2..16
//  SEL_W        $clog2(NUM_DIGITS)  index width (localparam, not overridable)
//  REFRESH_DIV  100000  clk cycles per digit slot, >= BLANK_CYC+2
//  BLANK_CYC    16      dead cycles at start of each slot (anti-ghosting), >= 1
// PORTS
//  clk           in   1              system clock, rising edge
//  rst_n         in   1              asynchronous active-low reset
//  enable        in   1              1 = scanning; 0 = prescaler/index hold, display dark
//  digit_data    in   4*NUM_DIGITS   hex nibble per digit; digit k = [4k+3:4k]
//  digit_en      in   NUM_DIGITS     per-digit enable mask
//  dp_in         in   NUM_DIGITS     per-digit decimal point, 1 = lit
//  anode_out     out  NUM_DIGITS     active-low one-hot anodes
//  seg_out       out  7              active-low segments {g,f,e,d,c,b,a}
//  dp_out        out  1              active-low decimal point
//  anode_driver  out  SEL_W          current digit index
//  frame_tick    out  1              1-cycle pulse at end of last slot
// BEHAVIOUR
//  Reset (async, rst_n=0): prescaler=0, anode_driver=0, shadows=0, anode_out=all 1, seg_out=7'h7F,
//   dp_out=1, frame_tick=0.
//  Prescaler cnt: counts 0..REFRESH_DIV-1 when enable=1.
//   At REFRESH_DIV-1: cnt->0; anode_driver increments, wrapping NUM_DIGITS-1 -> 0.
//  frame_tick: registered, high in the cycle after cnt=REFRESH_DIV-1 while anode_driver=NUM_DIGITS-1.
//  Shadow regs (data, en, dp): load from inputs on the same edge frame_tick is set.
//   Also load every cycle while enable=0 (transparent).
//   Input changes mid-frame never alter the displayed frame (no tearing).
//  Outputs registered; 1-cycle latency from cnt/anode_driver to pins:
//   Lit: enable=1, cnt>=BLANK_CYC, en_sh[idx]=1.
//    anode_out = ~(1<<idx); seg_out = hex7(data_sh[idx]); dp_out = ~dp_sh[idx].
//   Otherwise: anode_out all 1, seg_out=7'h7F, dp_out=1. A disabled digit still consumes its slot time.
//  hex7 (active-low):
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//   8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
//  enable falling: next edge outputs go dark; cnt and index hold.
//   Rising: resume from held cnt/index.
//  Never more than one anode low; anode_out never X after reset.
//  Reset mid-slot: immediate dark outputs, restart at digit 0, cnt 0.
// CONFIGURATION
//  SEG_DIM_EN defined: adds input brightness[3:0].
//   Lit additionally requires (cnt-BLANK_CYC) < ((brightness+1)*(REFRESH_DIV-BLANK_CYC))>>4.
//   Product uses 32-bit arithmetic. brightness=15 equals the undimmed behaviour.
//   brightness is sampled into the shadow with the data.
//  SEG_DIM_EN undefined: no brightness port; lit for the full post-blank slot.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1)
//  Reset, enable=0, data=16'h1234, en=4'hF, dp=0, then enable=1:
//   slot0 cnt0 dark; cnt1..3 -> anode_out=4'b1110, seg_out=7'h19, dp_out=1.
//   Next slot -> anode_out=4'b1101, seg_out=7'h30.
//  Run 16 cycles: anode_driver 0,1,2,3,0;
//   frame_tick exactly once per 16 cycles, after cnt=3 at idx=3.
//  Change data to 16'hABCD mid-frame: display holds 1234 until frame_tick, then digit0 seg_out=7'h21.
//  en=4'b0101: slots 1,3 anode_out=4'hF, seg_out=7'h7F for all 4 cycles; slot period unchanged.
//  dp=4'b0010: dp_out=0 only during slot1 lit cycles.
//  Pulse rst_n low mid slot2: outputs dark asynchronously; after release, restart at idx 0, cnt 0.
//  SEG_DIM_EN, REFRESH_DIV=17, BLANK_CYC=1, brightness=3: anode low 4 of the 16 post-blank cycles.

Source files
------------

// File: rtl/anode_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: prescaled digit slots, blanking, per-digit enable
// and frame-synchronous shadowing. Optional brightness dimming is enabled with `define SEG_DIM_EN.
module anode_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  localparam int SEL_W      = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEG_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   anode_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [SEL_W-1:0]        anode_driver,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [SEL_W-1:0]        idx, idx_nxt;
  logic                    slot_end, frame_end, load_sh;
  logic [4*NUM_DIGITS-1:0] data_sh;
  logic [NUM_DIGITS-1:0]   en_sh, dp_sh;
  logic                    lit, dim_ok;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] r;
    r = 7'h7F;
    case (nib)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
    endcase
    return r;
  endfunction

  // Prescaler and digit index advance only while enabled; disabled means hold.
  always_comb begin
    slot_end  = enable && (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    load_sh   = !enable || frame_end;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (enable) begin
      if (slot_end) begin
        cnt_nxt = '0;
        idx_nxt = (idx == IDX_LAST) ? '0 : idx + SEL_W'(1);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

`ifdef SEG_DIM_EN
  logic [3:0]  bright_sh;
  logic [31:0] on_len;

  always_comb begin
    on_len = ((32'(bright_sh) + 32'd1) * 32'(REFRESH_DIV - BLANK_CYC)) >> 4;
    dim_ok = (32'(cnt) - 32'(BLANK_CYC)) < on_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bright_sh <= '0;
    else if (load_sh) bright_sh <= brightness;
  end
`else
  assign dim_ok = 1'b1;
`endif

  // Decode from the pre-edge slot position so pins lag cnt/idx by exactly one cycle.
  always_comb begin
    cur_nib   = data_sh[{idx, 2'b00} +: 4];
    lit       = enable && (cnt >= CNT_BLANK) && en_sh[idx] && dim_ok;
    anode_nxt = '1;
    seg_nxt   = 7'h7F;
    dp_nxt    = 1'b1;
    if (lit) begin
      anode_nxt[idx] = 1'b0;
      seg_nxt        = hex7(cur_nib);
      dp_nxt         = ~dp_sh[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      data_sh    <= '0;
      en_sh      <= '0;
      dp_sh      <= '0;
      anode_out  <= '1;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      anode_out  <= anode_nxt;
      seg_out    <= seg_nxt;
      dp_out     <= dp_nxt;
      frame_tick <= frame_end;
      if (load_sh) begin
        data_sh <= digit_data;
        en_sh   <= digit_en;
        dp_sh   <= dp_in;
      end
    end
  end

  assign anode_driver = idx;

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Randomized scoreboard bench for anode_scan_ctrl (4 digits, 4-cycle slots, 1 blank cycle);
// the reference model derives every slot position from a running count of enabled cycles.
module tb_anode_scan_ctrl;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int W     = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] digit_data;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [3:0]  brightness;
  logic [3:0]  anode_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [1:0]  anode_driver;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [6:0]   hex_tab[16];

  anode_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digit_data(digit_data),
    .digit_en(digit_en), .dp_in(dp_in),
`ifdef SEG_DIM_EN
    .brightness(brightness),
`endif
    .anode_out(anode_out), .seg_out(seg_out), .dp_out(dp_out),
    .anode_driver(anode_driver), .frame_tick(frame_tick)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: state is just the number of enabled cycles since reset and a frame snapshot.
  int unsigned en_cycles = 0;
  int unsigned m_cnt, m_idx, m_idx_after;
  logic [15:0] snap_data = '0;
  logic [3:0]  snap_en = '0, snap_dp = '0, snap_br = '0;
  logic        m_lit, m_ft;
  logic [3:0]  m_anode, m_nib;
  logic [6:0]  m_seg;
  logic        m_dp;

  always @(posedge clk) begin
    if (!rst_n) begin
      en_cycles = 0;
      snap_data = '0; snap_en = '0; snap_dp = '0; snap_br = '0;
      exp_q.push_back({4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    end else begin
      m_cnt = en_cycles % DIV;
      m_idx = (en_cycles / DIV) % N;
      m_nib = snap_data[m_idx*4 +: 4];
      m_lit = enable && (m_cnt >= BLANK) && snap_en[m_idx];
`ifdef SEG_DIM_EN
      m_lit = m_lit && ((m_cnt - BLANK) < (((snap_br + 1) * (DIV - BLANK)) >> 4));
`endif
      m_anode = 4'hF;
      if (m_lit) m_anode[m_idx] = 1'b0;
      m_seg = m_lit ? hex_tab[m_nib] : 7'h7F;
      m_dp  = m_lit ? ~snap_dp[m_idx] : 1'b1;
      m_ft  = enable && (m_cnt == DIV - 1) && (m_idx == N - 1);
      if (!enable || m_ft) begin
        snap_data = digit_data; snap_en = digit_en; snap_dp = dp_in; snap_br = brightness;
      end
      if (enable) en_cycles++;
      m_idx_after = (en_cycles / DIV) % N;
      exp_q.push_back({m_anode, m_seg, m_dp, 2'(m_idx_after), m_ft});
    end
  end

  // Scoreboard monitor
  logic [W-1:0] exp_v, got_v;
  always @(posedge clk) begin
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry at %0t", $time);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {anode_out, seg_out, dp_out, anode_driver, frame_tick};
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_out @%0t: got anode=%b seg=%h dp=%b idx=%0d ft=%b, expected anode=%b seg=%h dp=%b idx=%0d ft=%b",
                 $time, got_v[14:11], got_v[10:4], got_v[3], got_v[2:1], got_v[0],
                 exp_v[14:11], exp_v[10:4], exp_v[3], exp_v[2:1], exp_v[0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_cycle();
    @(negedge clk);
    if ($urandom_range(0, 7) == 0)  digit_data = 16'($urandom);
    if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
    if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
    if ($urandom_range(0, 24) == 0) enable = ~enable;
`ifdef SEG_DIM_EN
    if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
`endif
  endtask

  int ft_count;
  int found;
  logic [15:0] sweep[4];

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    sweep = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    rst_n = 1'b0; enable = 1'b0; digit_data = 16'h1234; digit_en = 4'hF;
    dp_in = 4'h0; brightness = 4'hF;
    step(3);
    check("reset_anode", 32'(anode_out), 32'hF);
    check("reset_seg", 32'(seg_out), 32'h7F);
    rst_n = 1'b1;
    step(3);

    // First frame of 1234, frame_tick exactly once per 16 enabled cycles
    enable = 1'b1;
    ft_count = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      ft_count += int'(frame_tick);
      if (i == 1) check("slot0_blank", 32'(anode_out), 32'hF);
      if (i == 2) check("slot0_anode", 32'(anode_out), 32'b1110);
      if (i == 2) check("slot0_seg", 32'(seg_out), 32'h19);
      if (i == 5) check("idx_after_slot0", 32'(anode_driver), 32'd1);
      if (i == 6) check("slot1_anode", 32'(anode_out), 32'b1101);
      if (i == 6) check("slot1_seg", 32'(seg_out), 32'h30);
    end
    check("frame_tick_count", 32'(ft_count), 32'd1);

    // Mid-frame data change is deferred to the next frame
    step(6);
    digit_data = 16'hABCD;
    step(6);
    check("no_tearing_seg", 32'(seg_out), 32'h24);
    step(6);
    check("new_frame_anode", 32'(anode_out), 32'b1110);
    check("new_frame_seg", 32'(seg_out), 32'h21);

    // Disabled digits and decimal point
    digit_en = 4'b0101; dp_in = 4'b0010;
    step(48);
    digit_en = 4'b1111;
    step(32);

    // Hex decoder sweep
    foreach (sweep[k]) begin
      digit_data = sweep[k];
      dp_in = 4'($urandom);
      step(32);
    end

    // Randomized traffic including enable toggling
    for (int i = 0; i < 400; i++) rand_cycle();

    // Asynchronous reset in the middle of slot 2
    enable = 1'b1; digit_en = 4'hF;
    found = 0;
    for (int i = 0; i < 64 && found == 0; i++) begin
      @(negedge clk);
      if (((en_cycles / DIV) % N) == 2 && (en_cycles % DIV) == 2) found = 1;
    end
    check("seek_slot2", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_anode", 32'(anode_out), 32'hF);
    check("async_seg", 32'(seg_out), 32'h7F);
    check("async_dp", 32'(dp_out), 32'h1);
    check("async_idx", 32'(anode_driver), 32'd0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) rand_cycle();

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
